branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Direction predictor + target buffer feeding the IF stage of the 5-stage RV32I pipeline.
//  Looks up pc_f combinationally and returns a predicted-taken flag and target for next-PC select.
//  Carries each prediction through IF/ID and ID/EX under the hazard unit's stall/flush, presents it as br_pred_e.
//  Trains on resolved conditional branches in EX; keeps branch and mispredict counts for lab statistics.
// PARAMETERS
//  IDX_W    6   index bits; table holds 2**IDX_W direct-mapped entries
//  CNT_INIT 2   counter value (0..3) written on new-entry allocation (2 = weakly taken)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   synchronous reset, active high
//  pc_f           in   32  PC of the instruction being fetched
//  pred_taken_f   out  1   predict taken for pc_f (combinational)
//  pred_target_f  out  32  predicted target for pc_f (combinational; 0 when pred_taken_f=0)
//  fStall         in   1   from hazard unit; IF stage holds
//  dStall         in   1   from hazard unit; IF/ID register holds
//  dFlush         in   1   from hazard unit; IF/ID register clears
//  eFlush         in   1   from hazard unit; ID/EX register clears
//  br_e           in   1   instruction in EX is a conditional branch (beq/bne/blt/...)
//  branch         in   1   actual outcome of EX branch, 1 = taken (valid when br_e=1)
//  pc_e           in   32  PC of EX instruction
//  target_e       in   32  computed taken target of EX branch (pc_e + imm)
//  br_pred_e      out  1   prediction that was made for the instruction now in EX
//  br_cnt         out  32  resolved conditional branches since reset
//  miss_cnt       out  32  mispredicted conditional branches since reset
// BEHAVIOUR
//  Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]; index = pc[IDX_W+1:2].
//  Lookup: hit = valid & tag match; pred_taken_f = hit & ctr[1]; pred_target_f = hit&ctr[1] ? target : 0.
//  Table read is asynchronous from registers; a same-cycle write is NOT bypassed (lookup sees pre-edge state).
//  Prediction pipe: pred_d (IF/ID), br_pred_e (ID/EX), one stage per cycle.
//   pred_d  : dFlush -> 0; else dStall -> hold; else <= pred_taken_f.
//   br_pred_e: eFlush -> 0; else <= pred_d. Flush beats stall in every register.
//   Load-use (dStall=1,eFlush=1): pred_d holds, br_pred_e becomes 0 (bubble).
//  Training (on edge when br_e=1; independent of stall/flush inputs of that cycle):
//   hit & branch  : ctr <= sat_inc(ctr); target <= target_e.
//   hit & !branch : ctr <= sat_dec(ctr).
//   miss & branch : allocate: valid<=1, tag, target<=target_e, ctr<=CNT_INIT.
//   miss & !branch: no change.
//   Saturation: 3 stays 3 on inc, 0 stays 0 on dec.
//  Statistics: br_e -> br_cnt+1; br_e & (branch ^ br_pred_e) -> miss_cnt+1; both wrap at 2**32.
//  br_e=0: table and counters unchanged, regardless of branch value.
//  Reset: all valid=0, ctr=0, target=0, tag=0; pred_d=0, br_pred_e=0, br_cnt=0, miss_cnt=0.
//   Reset mid-training discards the pending update. Outputs pred_taken_f=0 from first post-reset cycle.
//  Jumps (jal/jalr) never train (br_e=0); their flushes arrive via dFlush/eFlush only.
// TESTING
//  rst, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0, br_pred_e=0, counts 0.
//  br_e=1,branch=1,pc_e=0x100,target_e=0x80 once -> next cycle pc_f=0x100 gives pred_taken_f=1, target 0x80; miss_cnt=1.
//  Same branch: taken x3 then not-taken x2 -> ctr 2->3->3->2->1; pred_taken_f=0 after second not-taken.
//  Aliasing: train 0x100 taken, then pc_f=0x100+4*2**IDX_W -> pred_taken_f=0 (tag miss); taken there replaces entry.
//  pc_f hit predicted, dStall=1,eFlush=1 for 1 cycle -> br_pred_e=0 that cycle, then 1 on following cycle.
//  dFlush=1 and dStall=1 same cycle with pred_d=1 -> pred_d=0 next cycle; br_e=1,branch=0 on br_pred_e=1 -> miss_cnt+1.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit direction predictor with target buffer for the RV32I fetch stage.
// The prediction is carried alongside the instruction to EX, where resolved branches train the table.
module branch_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        fStall,
  input  logic        dStall,
  input  logic        dFlush,
  input  logic        eFlush,
  input  logic        br_e,
  input  logic        branch,
  input  logic [31:0] pc_e,
  input  logic [31:0] target_e,
  output logic        br_pred_e,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_e;
  logic             hit_f;
  logic             hit_e;
  logic             pred_d;

  // The IF hold is realised by the fetch unit keeping pc_f stable; nothing to do here.
  logic unused_sig;
  assign unused_sig = &{1'b0, fStall, pc_f[1:0], pc_e[1:0]};

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // IF: asynchronous lookup, no bypass of a same-cycle training write
  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = pc_f[31:IDX_W+2];
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

  assign pred_taken_f  = hit_f && ctr_q[idx_f][1];
  assign pred_target_f = pred_taken_f ? target_q[idx_f] : 32'd0;

  // EX: training lookup on the resolving branch
  assign idx_e = pc_e[IDX_W+1:2];
  assign tag_e = pc_e[31:IDX_W+2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (br_e) begin
      if (hit_e) begin
        if (branch) begin
          ctr_q[idx_e]    <= sat_inc(ctr_q[idx_e]);
          target_q[idx_e] <= target_e;
        end else begin
          ctr_q[idx_e] <= sat_dec(ctr_q[idx_e]);
        end
      end else if (branch) begin
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= target_e;
        ctr_q[idx_e]    <= CNT_INIT;
      end
    end
  end

  // IF/ID and ID/EX: prediction follows the instruction; flush wins over stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_d    <= 1'b0;
      br_pred_e <= 1'b0;
    end else begin
      if (dFlush)      pred_d <= 1'b0;
      else if (!dStall) pred_d <= pred_taken_f;
      br_pred_e <= eFlush ? 1'b0 : pred_d;
    end
  end

  // EX: statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (br_e) begin
      br_cnt <= br_cnt + 32'd1;
      if (branch ^ br_pred_e) miss_cnt <= miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        fStall, dStall, dFlush, eFlush;
  logic        br_e, branch;
  logic [31:0] pc_e, target_e;
  logic        br_pred_e;
  logic [31:0] br_cnt, miss_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.IDX_W(6), .CNT_INIT(2'd2)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .fStall(fStall), .dStall(dStall), .dFlush(dFlush), .eFlush(eFlush),
    .br_e(br_e), .branch(branch), .pc_e(pc_e), .target_e(target_e),
    .br_pred_e(br_pred_e), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    br_e = 1'b1; branch = tk; pc_e = pc; target_e = tgt;
    tick();
    br_e = 1'b0; branch = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tg);
    pc_f = pc;
    #1;
    chk({tag, "_taken"}, pred_taken_f, exp_t);
    chk({tag, "_target"}, pred_target_f, exp_tg);
  endtask

  initial begin
    rst = 1'b1; pc_f = 32'h100; fStall = 0; dStall = 0; dFlush = 0; eFlush = 0;
    br_e = 0; branch = 0; pc_e = 0; target_e = 0;
    #2;
    tick(); tick();
    chk("rst_taken", pred_taken_f, 0);
    chk("rst_target", pred_target_f, 0);
    chk("rst_pred_e", br_pred_e, 0);
    chk("rst_br_cnt", br_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;

    // allocate 0x100 -> 0x80; lookup in the same cycle must not see it
    br_e = 1; branch = 1; pc_e = 32'h100; target_e = 32'h80;
    #1;
    chk("no_bypass", pred_taken_f, 0);
    tick();
    br_e = 0; branch = 0;
    look("alloc", 32'h100, 1, 32'h80);
    chk("alloc_miss", miss_cnt, 1);
    chk("alloc_br", br_cnt, 1);

    // ctr 2 -> 3 -> 3 -> 2 -> 1
    train(32'h100, 1, 32'h80);
    train(32'h100, 1, 32'h80);
    train(32'h100, 0, 32'h0);
    look("ctr2", 32'h100, 1, 32'h80);
    train(32'h100, 0, 32'h0);
    look("ctr1", 32'h100, 0, 32'h0);
    chk("ctr_br", br_cnt, 5);
    chk("ctr_miss", miss_cnt, 5);
    chk("ctr_pred_e", br_pred_e, 1);

    // saturate at 0, then climb back: 1 -> 0 -> 0 -> 1 -> 2
    train(32'h100, 0, 32'h0);
    train(32'h100, 0, 32'h0);
    look("sat0", 32'h100, 0, 32'h0);
    train(32'h100, 1, 32'h84);
    look("ctr_up1", 32'h100, 0, 32'h0);
    train(32'h100, 1, 32'h88);
    look("ctr_up2", 32'h100, 1, 32'h88);
    chk("sat_br", br_cnt, 9);

    // br_e=0 leaves everything alone
    br_e = 0; branch = 1; pc_e = 32'h104; target_e = 32'h44;
    tick();
    branch = 0;
    look("nobr_104", 32'h104, 0, 32'h0);
    chk("nobr_br", br_cnt, 9);

    // aliasing: 0x200 shares index 0 with 0x100
    look("alias_miss", 32'h200, 0, 32'h0);
    train(32'h200, 1, 32'h40);
    look("alias_new", 32'h200, 1, 32'h40);
    look("alias_old", 32'h100, 0, 32'h0);
    train(32'h104, 0, 32'h0);
    look("nt_noalloc", 32'h104, 0, 32'h0);

    // reset during a training cycle discards the update
    rst = 1; br_e = 1; branch = 1; pc_e = 32'h300; target_e = 32'h10; pc_f = 32'h200;
    tick();
    rst = 0; br_e = 0; branch = 0;
    look("rst2_200", 32'h200, 0, 32'h0);
    look("rst2_300", 32'h300, 0, 32'h0);
    chk("rst2_br", br_cnt, 0);
    chk("rst2_miss", miss_cnt, 0);

    pc_f = 32'h300;
    train(32'h200, 1, 32'h40);
    chk("tr_miss", miss_cnt, 1);

    // load-use bubble: pred_d holds while br_pred_e is cleared
    pc_f = 32'h200;
    tick(); tick();
    chk("pipe_pred_e", br_pred_e, 1);
    dStall = 1; eFlush = 1; pc_f = 32'h300;
    tick();
    chk("bubble_pred_e", br_pred_e, 0);
    dStall = 0; eFlush = 0;
    tick();
    chk("held_pred_e", br_pred_e, 1);
    tick();
    chk("next_pred_e", br_pred_e, 0);

    // flush beats stall, then a not-taken branch that was predicted taken
    pc_f = 32'h200;
    tick();
    dFlush = 1; dStall = 1;
    tick();
    chk("flush_pred_e", br_pred_e, 1);
    dFlush = 0; dStall = 0; pc_f = 32'h300;
    train(32'h300, 0, 32'h0);
    chk("flushed_pred_e", br_pred_e, 0);
    chk("mispred_miss", miss_cnt, 2);
    chk("mispred_br", br_cnt, 2);
    train(32'h300, 0, 32'h0);
    chk("correct_miss", miss_cnt, 2);
    chk("correct_br", br_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
